double_buffer_scheduler: RTL

DOUBLE_BUFFER_SCHEDULER -- requirements
Module: double_buffer_scheduler

---
 rtl/double_buffer_pkg.sv | 7 +
 rtl/idle_timer.sv | 19 +
 rtl/double_buffer_scheduler.sv | 81 ++++++++
 3 files changed

// File: rtl/double_buffer_pkg.sv
// double_buffer_pkg: shared FSM state type and default sizing for the double-buffer write scheduler
package double_buffer_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, HOLD, SWITCH} state_t;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts consecutive enabled cycles and flags the cycle that reaches the terminal count
module idle_timer #(
  parameter int TERMINAL_COUNT = 255
) (
  input  logic clock,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int CW = TERMINAL_COUNT > 1 ? $clog2(TERMINAL_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMINAL_COUNT - 1);
  logic [CW-1:0] count;
  assign done = enable && !clear && count == LAST;
  // restart on clear or expiry, otherwise advance while enabled
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) count <= '0;
    else count <= (clear || done) ? '0 : enable ? count + 1'b1 : count;
endmodule

// File: rtl/double_buffer_scheduler.sv
// double_buffer_scheduler: fills one half of a double buffer from a stream and publishes it to the consumer
module double_buffer_scheduler
  import double_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic                     inValid,
  input  logic [DATA_WIDTH-1:0]    inData,
  input  logic                     inLast,
  output logic                     inReady,
  output logic                     bufWriteEnable,
  output logic [DATA_WIDTH-1:0]    bufDataIn,
  output logic                     bufSwitch,
  input  logic                     bufFull,
  input  logic                     consumerDone,
  output logic [ADDRESS_WIDTH-1:0] fillCount,
  output logic [15:0]              switchCount
);
  localparam logic [ADDRESS_WIDTH-1:0] CAPACITY = '1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_SLOT = CAPACITY - 1'b1;
  state_t state;
  logic consumer_busy;
  logic accept;
  logic done_seen;
  logic seal;
  logic timeout;
  assign inReady = nReset && (state == IDLE || state == FILL) && !bufFull && fillCount != CAPACITY;
  assign accept = inValid && inReady;
  assign done_seen = consumerDone && consumer_busy;
  assign seal = accept && (inLast || fillCount == LAST_SLOT);
  idle_timer #(.TERMINAL_COUNT(TIMEOUT_CYCLES)) u_idle_timer (
    .clock(clock),
    .nReset(nReset),
    .clear(state != FILL || accept),
    .enable(state == FILL && !accept),
    .done(timeout)
  );
  // write path, fill/switch bookkeeping and the buffer hand-off state machine
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      consumer_busy <= 1'b0;
      fillCount <= '0;
      switchCount <= '0;
      bufWriteEnable <= 1'b0;
      bufDataIn <= '0;
      bufSwitch <= 1'b0;
    end else begin
      bufWriteEnable <= accept;
      if (accept) bufDataIn <= inData;
      if (accept) fillCount <= fillCount + 1'b1;
      if (done_seen) consumer_busy <= 1'b0;
      bufSwitch <= 1'b0;
      case (state)
        IDLE: if (accept) state <= seal ? DRAIN : FILL;
        FILL: if (seal || timeout) state <= DRAIN;
        DRAIN:
          if (fillCount == '0) state <= IDLE;
          else if (!consumer_busy || done_seen) begin
            state <= SWITCH;
            bufSwitch <= 1'b1;
          end else state <= HOLD;
        HOLD:
          if (done_seen) begin
            state <= SWITCH;
            bufSwitch <= 1'b1;
          end
        SWITCH: begin
          state <= IDLE;
          fillCount <= '0;
          consumer_busy <= 1'b1;
          if (~&switchCount) switchCount <= switchCount + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
